// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared types and BCD limits for the mm:ss stopwatch.
// Optional adjust feature is enabled with STOPWATCH_ADJUST_EN.
package stopwatch_bcd_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ONES_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_bcd_counter_bcd_mod60_digit_pair.sv
// Two-digit BCD counter 00..59; carry pulses on the 59 -> 00 step.
module bcd_mod60_digit_pair
    import stopwatch_bcd_counter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_carry
);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       w_ones_max;
    logic       w_tens_max;

    assign w_ones_max = (r_ones == BCD_ONES_MAX);
    assign w_tens_max = (r_tens == BCD_TENS_MAX);
    assign o_carry    = i_inc & w_ones_max & w_tens_max;
    assign o_tens     = r_tens;
    assign o_ones     = r_ones;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (i_inc) begin
            if (w_ones_max) begin
                r_ones <= 4'd0;
                r_tens <= w_tens_max ? 4'd0 : r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// mm:ss BCD stopwatch driven by rising edges of a divided clock level.
// Define STOPWATCH_ADJUST_EN to add adj/adj_sel field setting.
module stopwatch_bcd_counter
    import stopwatch_bcd_counter_pkg::*;
#(
    parameter int TICKS_PER_INC = 1
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       div_clk,
    input  logic       run_toggle,
    input  logic       clear,
`ifdef STOPWATCH_ADJUST_EN
    input  logic       adj,
    input  logic       adj_sel,
`endif
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       tick_out,
    output logic       wrap
);

    localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_INC - 1);

    logic       r_s0;
    logic       r_s1;
    logic       r_s2;
    logic       r_tick_out;
    state_t     r_state;
    logic [7:0] r_prescale;
    logic       r_running;
    logic       r_wrap;

    logic       w_tick;
    logic       w_run;
    logic       w_cnt_tick;
    logic       w_inc;
    logic       w_adj_sec;
    logic       w_adj_min;
    logic       w_sec_inc;
    logic       w_min_inc;
    logic       w_sec_carry;
    logic       w_min_carry;
    logic       w_clr;

    assign w_tick     = r_s1 & ~r_s2;
    assign w_run      = (r_state == ST_RUN);
    assign w_cnt_tick = w_run & w_tick & ~clear;
    assign w_inc      = w_cnt_tick & (r_prescale == PRE_LAST);
    assign w_clr      = clear;

`ifdef STOPWATCH_ADJUST_EN
    // Adjust bypasses the prescaler and never carries across fields
    assign w_adj_sec = ~w_run & w_tick & ~clear & adj & ~adj_sel;
    assign w_adj_min = ~w_run & w_tick & ~clear & adj & adj_sel;
`else
    assign w_adj_sec = 1'b0;
    assign w_adj_min = 1'b0;
`endif

    assign w_sec_inc = w_inc | w_adj_sec;
    assign w_min_inc = (w_inc & w_sec_carry) | w_adj_min;

    bcd_mod60_digit_pair u_sec (
        .i_clk   (clk_in),
        .i_rst   (rst),
        .i_clr   (w_clr),
        .i_inc   (w_sec_inc),
        .o_tens  (sec_tens),
        .o_ones  (sec_ones),
        .o_carry (w_sec_carry)
    );

    bcd_mod60_digit_pair u_min (
        .i_clk   (clk_in),
        .i_rst   (rst),
        .i_clr   (w_clr),
        .i_inc   (w_min_inc),
        .o_tens  (min_tens),
        .o_ones  (min_ones),
        .o_carry (w_min_carry)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_tick_out <= 1'b0;
        end else begin
            r_s0       <= div_clk;
            r_s1       <= r_s0;
            r_s2       <= r_s1;
            r_tick_out <= w_tick;
        end
    end

    // Counting uses the state before any toggle in the same cycle
    always_ff @(posedge clk_in) begin
        if (rst || clear) begin
            r_state    <= ST_IDLE;
            r_running  <= 1'b0;
            r_prescale <= 8'd0;
            r_wrap     <= 1'b0;
        end else begin
            r_wrap <= w_inc & w_min_carry;
            if (w_cnt_tick) begin
                r_prescale <= (r_prescale == PRE_LAST) ? 8'd0
                                                       : r_prescale + 8'd1;
            end
            if (run_toggle) begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                    ST_RUN: begin
                        r_state   <= ST_PAUSED;
                        r_running <= 1'b0;
                    end
                    ST_PAUSED: begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign running  = r_running;
    assign tick_out = r_tick_out;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Randomized bench: two stopwatches (1 and 4 ticks per second) vs a
// model that keeps elapsed time as a plain seconds count.
module tb_stopwatch_bcd_counter;

    logic clk = 1'b0;
    logic rst, div_clk, run_toggle, clear;
`ifdef STOPWATCH_ADJUST_EN
    logic adj, adj_sel;
`endif
    logic [3:0] mt1, mo1, st1, so1, mt4, mo4, st4, so4;
    logic run1, tko1, wr1, run4, tko4, wr4;

    int n_checks = 0;
    int n_err    = 0;
    int wrap1_cnt = 0;

    always #5 clk = ~clk;

    stopwatch_bcd_counter #(.TICKS_PER_INC(1)) u_dut1 (
        .clk_in(clk), .rst(rst), .div_clk(div_clk),
        .run_toggle(run_toggle), .clear(clear),
`ifdef STOPWATCH_ADJUST_EN
        .adj(adj), .adj_sel(adj_sel),
`endif
        .min_tens(mt1), .min_ones(mo1), .sec_tens(st1), .sec_ones(so1),
        .running(run1), .tick_out(tko1), .wrap(wr1)
    );

    stopwatch_bcd_counter #(.TICKS_PER_INC(4)) u_dut4 (
        .clk_in(clk), .rst(rst), .div_clk(div_clk),
        .run_toggle(run_toggle), .clear(clear),
`ifdef STOPWATCH_ADJUST_EN
        .adj(adj), .adj_sel(adj_sel),
`endif
        .min_tens(mt4), .min_ones(mo4), .sec_tens(st4), .sec_ones(so4),
        .running(run4), .tick_out(tko4), .wrap(wr4)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_tot[2];
    int  m_pre[2];
    bit  m_wrap[2];
    int  m_st;          // 0 idle, 1 run, 2 paused
    bit  m_tick_out;
    bit  m_valid = 0;
    bit  d1, d2, d3;    // div_clk seen 1, 2, 3 edges ago

    function automatic int tpi(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    always @(posedge clk) begin
        bit tk;
        tk = d2 & ~d3;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_tot[i] = 0; m_pre[i] = 0; m_wrap[i] = 0;
            end
            m_st = 0; m_tick_out = 0;
            d1 = 0; d2 = 0; d3 = 0;
        end else begin
            m_tick_out = tk;
            for (int i = 0; i < 2; i++) m_wrap[i] = 0;
            if (clear) begin
                for (int i = 0; i < 2; i++) begin
                    m_tot[i] = 0; m_pre[i] = 0;
                end
                m_st = 0;
            end else begin
                if (m_st == 1 && tk) begin
                    for (int i = 0; i < 2; i++) begin
                        if (m_pre[i] == tpi(i) - 1) begin
                            m_pre[i] = 0;
                            if (m_tot[i] == 3599) m_wrap[i] = 1;
                            m_tot[i] = (m_tot[i] + 1) % 3600;
                        end else begin
                            m_pre[i]++;
                        end
                    end
                end
`ifdef STOPWATCH_ADJUST_EN
                if (m_st != 1 && tk && adj) begin
                    for (int i = 0; i < 2; i++) begin
                        int s, m;
                        s = m_tot[i] % 60;
                        m = m_tot[i] / 60;
                        if (adj_sel) m = (m + 1) % 60;
                        else         s = (s + 1) % 60;
                        m_tot[i] = m * 60 + s;
                    end
                end
`endif
                if (run_toggle) m_st = (m_st == 1) ? 2 : 1;
            end
            d3 = d2; d2 = d1; d1 = div_clk;
        end
        m_valid = 1;
    end

    task automatic cmp_inst(input string p, input int i,
                            input logic [3:0] mt, input logic [3:0] mo,
                            input logic [3:0] st, input logic [3:0] so,
                            input logic rn, input logic tko, input logic wr);
        check({p, "_min_tens"}, int'(mt), m_tot[i] / 600);
        check({p, "_min_ones"}, int'(mo), (m_tot[i] / 60) % 10);
        check({p, "_sec_tens"}, int'(st), (m_tot[i] % 60) / 10);
        check({p, "_sec_ones"}, int'(so), m_tot[i] % 10);
        check({p, "_running"}, int'(rn), int'(m_st == 1));
        check({p, "_tick_out"}, int'(tko), int'(m_tick_out));
        check({p, "_wrap"}, int'(wr), int'(m_wrap[i]));
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            cmp_inst("d1", 0, mt1, mo1, st1, so1, run1, tko1, wr1);
            cmp_inst("d4", 1, mt4, mo4, st4, so4, run4, tko4, wr4);
            if (wr1 === 1'b1) wrap1_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic edge_rise(input int hi, input int lo);
        div_clk = 1'b1;
        repeat (hi) @(negedge clk);
        div_clk = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic rises(input int n, input bit fast);
        for (int k = 0; k < n; k++) begin
            if (fast) edge_rise(1, 1);
            else edge_rise($urandom_range(1, 3), $urandom_range(1, 3));
        end
    endtask

    task automatic pulse_toggle();
        run_toggle = 1'b1;
        @(negedge clk);
        run_toggle = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic pin1(input string nm, input int mt, input int mo,
                        input int st, input int so);
        check({nm, "_mt"}, int'(mt1), mt);
        check({nm, "_mo"}, int'(mo1), mo);
        check({nm, "_st"}, int'(st1), st);
        check({nm, "_so"}, int'(so1), so);
    endtask

    initial begin
        rst = 1'b1; div_clk = 1'b0; run_toggle = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_ADJUST_EN
        adj = 1'b0; adj_sel = 1'b0;
`endif
        @(negedge clk);
        rises(6, 1'b1);
        div_clk = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        div_clk = 1'b0;
        @(negedge clk);
        rises(10, 1'b0);
        settle();
        pin1("idle", 0, 0, 0, 0);
        check("idle_running", int'(run1), 0);
        check("idle_wrap_cnt", wrap1_cnt, 0);

        pulse_toggle();
        settle();
        div_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lat_before", int'(so1), 0);
        @(negedge clk);
        check("lat_after", int'(so1), 1);
        div_clk = 1'b0;
        @(negedge clk);
        rises(60, 1'b0);
        settle();
        pin1("run61", 0, 1, 0, 1);
        check("run61_d4_st", int'(st4), 1);
        check("run61_d4_so", int'(so4), 5);

        rises(3537, 1'b1);
        settle();
        pin1("pre5958", 5, 9, 5, 8);
        wrap1_cnt = 0;
        rises(1, 1'b1);
        settle();
        pin1("at5959", 5, 9, 5, 9);
        rises(1, 1'b1);
        settle();
        pin1("wrapped", 0, 0, 0, 0);
        check("wrap_cycles", wrap1_cnt, 1);
        check("wrap_running", int'(run1), 1);

        div_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run_toggle = 1'b1;
        @(negedge clk);
        run_toggle = 1'b0;
        div_clk = 1'b0;
        settle();
        pin1("pause_tick", 0, 0, 0, 1);
        check("pause_running", int'(run1), 0);
        rises(5, 1'b0);
        settle();
        pin1("paused_hold", 0, 0, 0, 1);
        pulse_toggle();
        rises(6, 1'b0);
        settle();
        pin1("at0007", 0, 0, 0, 7);

        div_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run_toggle = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        run_toggle = 1'b0;
        clear = 1'b0;
        div_clk = 1'b0;
        settle();
        pin1("cleared", 0, 0, 0, 0);
        check("cleared_running", int'(run1), 0);
        pulse_toggle();
        rises(3, 1'b0);
        settle();
        check("d4_three_edges", int'(so4), 0);
        rises(1, 1'b0);
        settle();
        check("d4_four_edges", int'(so4), 1);

        rises(5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        settle();
        pin1("mid_rst", 0, 0, 0, 0);

        for (int k = 0; k < 3000; k++) begin
            div_clk    = 1'($urandom_range(0, 1));
            run_toggle = ($urandom_range(0, 15) == 0);
            clear      = ($urandom_range(0, 60) == 0);
`ifdef STOPWATCH_ADJUST_EN
            adj     = 1'($urandom_range(0, 1));
            adj_sel = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
        end
        run_toggle = 1'b0;
        clear = 1'b0;
        div_clk = 1'b0;
`ifdef STOPWATCH_ADJUST_EN
        adj = 1'b0;
        settle();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        pulse_toggle();
        pulse_toggle();
        settle();
        wrap1_cnt = 0;
        adj = 1'b1;
        adj_sel = 1'b1;
        rises(61, 1'b0);
        adj = 1'b0;
        settle();
        pin1("adj_min", 0, 1, 0, 0);
        check("adj_wrap_cnt", wrap1_cnt, 0);
        check("adj_running", int'(run1), 0);
`endif
        settle();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
